// File: rtl/arqui_pkg.sv
// Shared constants, state encoding and helpers for the arqui sequencing controller.
// The optional threshold sanity check is enabled with the ARQUI_THRESH_CHECK_EN macro.
package arqui_pkg;

    localparam int NFIFO   = 5;
    localparam int IDX_MF  = 0;
    localparam int IDX_VC0 = 1;
    localparam int IDX_VC1 = 2;
    localparam int IDX_D0  = 3;
    localparam int IDX_D1  = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b011,
        ST_ERROR  = 3'b100
    } state_t;

    // A push into a full FIFO or a pop from an empty one is an error on that FIFO.
    function automatic logic [NFIFO-1:0] calc_err_now(
        input logic [NFIFO-1:0] push,
        input logic [NFIFO-1:0] pop,
        input logic [NFIFO-1:0] full,
        input logic [NFIFO-1:0] empty
    );
        return (push & full) | (pop & empty);
    endfunction

endpackage

// File: rtl/arqui_err_mon.sv
// Per-FIFO overflow/underflow detection with a sticky error register.
// clr has priority; set_vec injects extra error bits from the controller.
module arqui_err_mon
    import arqui_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    input  logic [NFIFO-1:0] fifo_push,
    input  logic [NFIFO-1:0] fifo_pop,
    input  logic [NFIFO-1:0] fifo_full,
    input  logic [NFIFO-1:0] fifo_empty,
    input  logic             clr,
    input  logic             en,
    input  logic [NFIFO-1:0] set_vec,
    output logic [NFIFO-1:0] err_now,
    output logic [NFIFO-1:0] error_out
);

    logic [NFIFO-1:0] err_r;

    assign err_now   = calc_err_now(fifo_push, fifo_pop, fifo_full, fifo_empty);
    assign error_out = err_r;

    // Sticky error accumulation; cleared when the controller re-initialises.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_r <= '0;
        end else if (clr) begin
            err_r <= '0;
        end else begin
            err_r <= err_r | (en ? err_now : {NFIFO{1'b0}}) | set_vec;
        end
    end

endmodule

// File: rtl/arqui_ctrl_fsm.sv
// Top-level sequencing controller: threshold capture, IDLE/ACTIVE tracking, sticky errors.
// Define ARQUI_THRESH_CHECK_EN to reject af<=ae threshold pairs when leaving INIT.
module arqui_ctrl_fsm
    import arqui_pkg::*;
#(
    parameter int MF_W = 2,
    parameter int VC_W = 4,
    parameter int DF_W = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [MF_W-1:0]  afMF_i,
    input  logic [MF_W-1:0]  aeMF_i,
    input  logic [VC_W-1:0]  afVC_i,
    input  logic [VC_W-1:0]  aeVC_i,
    input  logic [DF_W-1:0]  afDF_i,
    input  logic [DF_W-1:0]  aeDF_i,
    input  logic [NFIFO-1:0] fifo_push,
    input  logic [NFIFO-1:0] fifo_pop,
    input  logic [NFIFO-1:0] fifo_full,
    input  logic [NFIFO-1:0] fifo_empty,
    output logic [MF_W-1:0]  afMF_o,
    output logic [MF_W-1:0]  aeMF_o,
    output logic [VC_W-1:0]  afVC_o,
    output logic [VC_W-1:0]  aeVC_o,
    output logic [DF_W-1:0]  afDF_o,
    output logic [DF_W-1:0]  aeDF_o,
    output logic             active_out,
    output logic             idle_out,
    output logic [NFIFO-1:0] error_out,
    output logic [2:0]       state_out
);

    state_t           state_r, state_nxt_s;
    logic             active_r, idle_r;
    logic [MF_W-1:0]  af_mf_r, ae_mf_r;
    logic [VC_W-1:0]  af_vc_r, ae_vc_r;
    logic [DF_W-1:0]  af_df_r, ae_df_r;
    logic [NFIFO-1:0] err_now_s, err_set_s;
    logic             err_clr_s, err_en_s;

`ifdef ARQUI_THRESH_CHECK_EN
    logic [NFIFO-1:0] thresh_fail_s;

    // Threshold pairs where almost-full does not sit above almost-empty are rejected.
    always_comb begin
        thresh_fail_s = {NFIFO{1'b0}};
        thresh_fail_s[IDX_MF]  = (afMF_i <= aeMF_i);
        thresh_fail_s[IDX_VC0] = (afVC_i <= aeVC_i);
        thresh_fail_s[IDX_VC1] = (afVC_i <= aeVC_i);
        thresh_fail_s[IDX_D0]  = (afDF_i <= aeDF_i);
        thresh_fail_s[IDX_D1]  = (afDF_i <= aeDF_i);
    end
`endif

    // Next-state and error-register control; errors outrank init, init outranks occupancy.
    always_comb begin
        state_nxt_s = state_r;
        err_set_s   = {NFIFO{1'b0}};
        case (state_r)
            ST_RESET: state_nxt_s = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    state_nxt_s = ST_INIT;
                end else begin
`ifdef ARQUI_THRESH_CHECK_EN
                    if (|thresh_fail_s) begin
                        state_nxt_s = ST_ERROR;
                        err_set_s   = thresh_fail_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`else
                    state_nxt_s = ST_IDLE;
`endif
                end
            end
            ST_IDLE: begin
                if (|err_now_s)         state_nxt_s = ST_ERROR;
                else if (init)          state_nxt_s = ST_INIT;
                else if (~&fifo_empty)  state_nxt_s = ST_ACTIVE;
                else                    state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (|err_now_s)         state_nxt_s = ST_ERROR;
                else if (init)          state_nxt_s = ST_INIT;
                else if (&fifo_empty)   state_nxt_s = ST_IDLE;
                else                    state_nxt_s = ST_ACTIVE;
            end
            ST_ERROR: begin
                if (init) state_nxt_s = ST_INIT;
                else      state_nxt_s = ST_ERROR;
            end
            default: state_nxt_s = ST_RESET;
        endcase
        err_en_s  = (state_r == ST_IDLE) || (state_r == ST_ACTIVE) || (state_r == ST_ERROR);
        err_clr_s = (state_nxt_s == ST_INIT) || (state_nxt_s == ST_RESET);
    end

    // State register with registered status decodes.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r  <= ST_RESET;
            active_r <= 1'b0;
            idle_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            active_r <= (state_nxt_s == ST_ACTIVE);
            idle_r   <= (state_nxt_s == ST_IDLE);
        end
    end

    // Thresholds track the inputs only while in INIT and freeze otherwise.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            af_mf_r <= '0;
            ae_mf_r <= '0;
            af_vc_r <= '0;
            ae_vc_r <= '0;
            af_df_r <= '0;
            ae_df_r <= '0;
        end else if (state_r == ST_INIT) begin
            af_mf_r <= afMF_i;
            ae_mf_r <= aeMF_i;
            af_vc_r <= afVC_i;
            ae_vc_r <= aeVC_i;
            af_df_r <= afDF_i;
            ae_df_r <= aeDF_i;
        end else begin
            af_mf_r <= af_mf_r;
            ae_mf_r <= ae_mf_r;
            af_vc_r <= af_vc_r;
            ae_vc_r <= ae_vc_r;
            af_df_r <= af_df_r;
            ae_df_r <= ae_df_r;
        end
    end

    arqui_err_mon u_err_mon (
        .clk        (clk),
        .reset_L    (reset_L),
        .fifo_push  (fifo_push),
        .fifo_pop   (fifo_pop),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .clr        (err_clr_s),
        .en         (err_en_s),
        .set_vec    (err_set_s),
        .err_now    (err_now_s),
        .error_out  (error_out)
    );

    assign state_out  = state_r;
    assign active_out = active_r;
    assign idle_out   = idle_r;
    assign afMF_o     = af_mf_r;
    assign aeMF_o     = ae_mf_r;
    assign afVC_o     = af_vc_r;
    assign aeVC_o     = ae_vc_r;
    assign afDF_o     = af_df_r;
    assign aeDF_o     = ae_df_r;

endmodule
